// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the round-robin tri-state bus arbiter.
// Holds the FSM state enum, counter width helpers and a onehot decoder.
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_t;

   // Counter width able to hold max_val, never narrower than 1 bit.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or
// above the pointer wins, wrapping past the top.
module rr_arbiter
   import tri_bus_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   localparam int PW = idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [PW-1:0]          ptr,
   output logic                   valid,
   output logic [PW-1:0]          winner
);

   logic [PW-1:0] j;

   // Scan from farthest to nearest so the nearest request wins last.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      j      = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % NUM_MASTERS);
         if (req[j]) begin
            valid  = 1'b1;
            winner = j;
         end
      end
   end

endmodule

// File: rtl/tri_state_bus_arbiter.sv
// Round-robin owner of one shared tri-state bus with burst cap and turnaround.
// Build option TRI_BUS_KEEPER_EN: hold the last driven value instead of Z.
module tri_state_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int NUM_MASTERS = 4,
   parameter int MAX_BURST   = 16,
   parameter int TURN_CYCLES = 1
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [NUM_MASTERS-1:0]       req_in,
   input  logic [NUM_MASTERS*WIDTH-1:0] data_in,
   output logic [NUM_MASTERS-1:0]       gnt_out,
   output logic                         bus_en_out,
   output logic [WIDTH-1:0]             data_bus_out,
   output logic                         busy_out
);

   localparam int PW = idx_w(NUM_MASTERS);
   localparam int BW = cnt_w(MAX_BURST);
   localparam int TW = cnt_w(TURN_CYCLES);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [TW-1:0] TURN_MAX  = TW'(TURN_CYCLES);

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    owner;
   logic [PW-1:0]    next_ptr;
   logic [PW-1:0]    pick;
   logic             pick_vld;
   logic [BW-1:0]    burst_cnt;
   logic [TW-1:0]    turn_cnt;
   logic             owner_req;
   logic             cap_hit;
   logic [WIDTH-1:0] drive_val;

   rr_arbiter #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_rr (
      .req   (req_in),
      .ptr   (ptr),
      .valid (pick_vld),
      .winner(pick)
   );

   assign owner     = PW'(onehot_to_idx(16'(gnt_out)));
   assign owner_req = |(req_in & gnt_out);
   assign cap_hit   = (MAX_BURST != 0) && (burst_cnt == BURST_MAX);
   assign next_ptr  = (int'(owner) == NUM_MASTERS - 1) ? '0 : owner + 1'b1;

   always_comb begin
      drive_val = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (gnt_out[i]) drive_val = drive_val | data_in[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         gnt_out    <= '0;
         bus_en_out <= 1'b0;
         busy_out   <= 1'b0;
         ptr        <= '0;
         burst_cnt  <= '0;
         turn_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  state      <= DRIVE;
                  gnt_out    <= NUM_MASTERS'(1) << pick;
                  bus_en_out <= 1'b1;
                  busy_out   <= 1'b1;
                  burst_cnt  <= BW'(1);
               end
            end
            DRIVE: begin
               if (!owner_req || cap_hit) begin
                  gnt_out    <= '0;
                  bus_en_out <= 1'b0;
                  ptr        <= next_ptr;
                  burst_cnt  <= '0;
                  if (TURN_CYCLES > 0) begin
                     state    <= TURN;
                     turn_cnt <= TW'(1);
                  end else begin
                     state    <= IDLE;
                     busy_out <= 1'b0;
                  end
               end else if (MAX_BURST != 0) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            TURN: begin
               if (turn_cnt == TURN_MAX) begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
                  turn_cnt <= '0;
               end else begin
                  turn_cnt <= turn_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TRI_BUS_KEEPER_EN
   logic [WIDTH-1:0] keep_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         keep_q <= '0;
      end else if (bus_en_out) begin
         keep_q <= drive_val;
      end
   end

   assign data_bus_out = bus_en_out ? drive_val : keep_q;
`else
   assign data_bus_out = bus_en_out ? drive_val : {WIDTH{1'bz}};
`endif

endmodule
